// File: rtl/next_pc_predictor_pkg.sv
// pred_pkg: shared constants and helpers for the next-PC predictor.
//   - RV32 opcodes the fetch-side predictor cares about
//   - FSM state encodings for next_pc_predictor
//   - imm_b / imm_j: sign-extended branch and JAL offsets (bit 0 always 0)
package pred_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] ST_BOOT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/next_pc_predictor_bht.sv
// bht_2bit: table of 2-bit saturating direction counters.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low; every entry returns to BHT_INIT
//   rd_idx     in   lookup index (fetch side)
//   rd_ctr     out  counter at rd_idx; reflects the value before any same-cycle update
//   upd_en     in   apply an update this cycle
//   upd_idx    in   index to update (resolve side)
//   upd_taken  in   1 = saturating increment, 0 = saturating decrement
module bht_2bit #(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_ctr,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  localparam int N_ENT = 1 << BHT_IDX_W;

  logic [1:0] ctr [N_ENT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ENT; i++) ctr[i] <= BHT_INIT;
    end else if (upd_en) begin
      if (upd_taken) begin
        if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
      end else begin
        if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
      end
    end
  end

  // Read straight from the array: a same-cycle update is only visible next cycle.
  assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/next_pc_predictor.sv
// next_pc_predictor: fetch-side next-PC generator with 2-bit bimodal prediction.
// Predicts B-type direction from the BHT, follows JAL statically, and redirects
// fetch (with flush) when EX reports a mispredicted control instruction.
// Optional build macro: PRED_STATS_EN adds resolved-branch / mispredict counters;
// without it stat_branches and stat_mispred are tied to 0.
// Ports:
//   clock, reset            clock and asynchronous active-low reset
//   pc, inst_code           current fetch PC and the instruction at it
//   stall                   hazard hold of fetch
//   ex_valid .. ex_pred_target  branch resolution from EX
//   next_pc, pc_write       PC register load value / enable
//   pred_taken              prediction for the current fetch
//   flush                   kill IF/ID and ID/EX
//   stat_branches, stat_mispred  statistics counters
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_BOOT    | first cycle after reset: load PC with 0
// ST_RUN     | normal prediction
// ST_RECOVER | cycle after a redirect: flush the stale IF/ID instruction
module next_pc_predictor
  import pred_pkg::*;
#(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst_code,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic        pred_taken,
  output logic        flush,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  logic [1:0] state;
  logic [1:0] bht_ctr;
  logic       mispredict;
  logic       bht_upd;

  // Gated with reset so outputs sit at their reset values while reset is held.
  assign mispredict = reset & ex_valid &
                      (ex_taken ? (!ex_pred_taken || (ex_target != ex_pred_target))
                                : ex_pred_taken);
  assign bht_upd    = ex_valid & ex_is_branch;

  bht_2bit #(
    .BHT_IDX_W (BHT_IDX_W),
    .BHT_INIT  (BHT_INIT)
  ) u_bht (
    .clock     (clock),
    .reset     (reset),
    .rd_idx    (pc[BHT_IDX_W+1:2]),
    .rd_ctr    (bht_ctr),
    .upd_en    (bht_upd),
    .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
    .upd_taken (ex_taken)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          state <= ST_BOOT;
    else if (mispredict) state <= ST_RECOVER;
    else                 state <= ST_RUN;
  end

  always_comb begin
    next_pc    = pc + 32'd4;
    pc_write   = 1'b1;
    pred_taken = 1'b0;
    if (mispredict) begin
      next_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    end else if (state == ST_BOOT) begin
      next_pc = 32'd0;
    end else if (stall) begin
      next_pc  = pc;
      pc_write = 1'b0;
    end else begin
      case (inst_code[6:0])
        OPC_BRANCH: begin
          if (bht_ctr[1]) begin
            next_pc    = pc + imm_b(inst_code);
            pred_taken = 1'b1;
          end
        end
        OPC_JAL: begin
          next_pc    = pc + imm_j(inst_code);
          pred_taken = 1'b1;
        end
        // JALR target depends on a register value, so fetch falls through.
        OPC_JALR: next_pc = pc + 32'd4;
        default:  next_pc = pc + 32'd4;
      endcase
    end
  end

  assign flush = mispredict | (state == ST_RECOVER);

`ifdef PRED_STATS_EN
  logic [31:0] cnt_branches;
  logic [31:0] cnt_mispred;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_branches <= 32'd0;
      cnt_mispred  <= 32'd0;
    end else begin
      if (bht_upd)    cnt_branches <= cnt_branches + 32'd1;
      if (mispredict) cnt_mispred  <= cnt_mispred + 32'd1;
    end
  end

  assign stat_branches = cnt_branches;
  assign stat_mispred  = cnt_mispred;
`else
  assign stat_branches = 32'd0;
  assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_next_pc_predictor.sv
module tb_next_pc_predictor;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'hFE00_08E3; // beq x0,x0,-16
  localparam logic [31:0] JAL  = 32'h0400_006F; // jal x0,+0x40
  localparam logic [31:0] JALR = 32'h0000_80E7; // jalr ra,0(ra)

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc, inst_code;
  logic        stall, ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [31:0] next_pc, stat_branches, stat_mispred;
  logic        pc_write, pred_taken, flush;

  next_pc_predictor dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .inst_code      (inst_code),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .next_pc        (next_pc),
    .pc_write       (pc_write),
    .pred_taken     (pred_taken),
    .flush          (flush),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        pcw;
    logic        pt;
    logic        fl;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt_br = 0;
  logic [31:0] cnt_mp = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "next_pc",    next_pc,           e.npc);
      chk(e.name, "pc_write",   {31'd0, pc_write},   {31'd0, e.pcw});
      chk(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
      chk(e.name, "flush",      {31'd0, flush},      {31'd0, e.fl});
      chk(e.name, "stat_br",    stat_branches,     e.sb);
      chk(e.name, "stat_mp",    stat_mispred,      e.sm);
    end
  end

  task automatic vec(input string nm, input logic rst_i,
                     input logic [31:0] pc_i, input logic [31:0] inst_i, input logic stl,
                     input logic exv, input logic exb, input logic [31:0] expc,
                     input logic ext, input logic [31:0] extgt,
                     input logic expt, input logic [31:0] exptgt,
                     input logic [31:0] e_npc, input logic e_pcw, input logic e_pt,
                     input logic e_fl, input logic e_mp);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst_i; pc = pc_i; inst_code = inst_i; stall = stl;
    ex_valid = exv; ex_is_branch = exb; ex_pc = expc; ex_taken = ext;
    ex_target = extgt; ex_pred_taken = expt; ex_pred_target = exptgt;
    if (!rst_i) begin
      cnt_br = 0;
      cnt_mp = 0;
    end
    e.name = nm; e.npc = e_npc; e.pcw = e_pcw; e.pt = e_pt; e.fl = e_fl;
`ifdef PRED_STATS_EN
    e.sb = cnt_br; e.sm = cnt_mp;
`else
    e.sb = 32'd0; e.sm = 32'd0;
`endif
    exp_q.push_back(e);
    if (rst_i) begin
      if (exv && exb) cnt_br++;
      if (e_mp) cnt_mp++;
    end
  endtask

  task automatic fetch(input string nm, input logic [31:0] pc_i, input logic [31:0] inst_i,
                       input logic stl, input logic [31:0] e_npc, input logic e_pcw,
                       input logic e_pt, input logic e_fl);
    vec(nm, 1'b1, pc_i, inst_i, stl, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
        e_npc, e_pcw, e_pt, e_fl, 1'b0);
  endtask

  task automatic res(input string nm, input logic [31:0] pc_i, input logic [31:0] inst_i,
                     input logic stl, input logic exb, input logic [31:0] expc,
                     input logic ext, input logic [31:0] extgt,
                     input logic expt, input logic [31:0] exptgt,
                     input logic [31:0] e_npc, input logic e_pcw, input logic e_pt,
                     input logic e_fl, input logic e_mp);
    vec(nm, 1'b1, pc_i, inst_i, stl, 1'b1, exb, expc, ext, extgt, expt, exptgt,
        e_npc, e_pcw, e_pt, e_fl, e_mp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; pc = 0; inst_code = NOP; stall = 0;
    ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;

    vec("reset", 1'b0, 32'h0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    vec("boot",  1'b1, 32'h0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    fetch("nop0",       32'h0,   NOP, 0, 32'h4,   1, 0, 0);
    fetch("beq_weak_n", 32'h100, BEQ, 0, 32'h104, 1, 0, 0);
    res("bht_tk1", 32'h400, NOP, 0, 1, 32'h100, 1, 32'hF0, 0, 32'h104, 32'hF0, 1, 0, 1, 1);
    res("bht_tk2", 32'h400, NOP, 0, 1, 32'h100, 1, 32'hF0, 0, 32'h104, 32'hF0, 1, 0, 1, 1);
    fetch("recover_pred", 32'h100, BEQ, 0, 32'hF0, 1, 1, 1);
    fetch("beq_taken",    32'h100, BEQ, 0, 32'hF0, 1, 1, 0);
    fetch("jal",          32'h200, JAL, 0, 32'h240, 1, 1, 0);
    res("jal_ok", 32'h204, NOP, 0, 0, 32'h200, 1, 32'h240, 1, 32'h240, 32'h208, 1, 0, 0, 0);
    fetch("jalr",         32'h500, JALR, 0, 32'h504, 1, 0, 0);
    res("mp_stall", 32'h310, NOP, 1, 1, 32'h300, 0, 32'h2F0, 1, 32'h2F0, 32'h304, 1, 0, 1, 1);
    fetch("mp_recover",   32'h304, NOP, 0, 32'h308, 1, 0, 1);
    fetch("stall",        32'h308, NOP, 1, 32'h308, 0, 0, 0);
    fetch("stall_beq",    32'h100, BEQ, 1, 32'h100, 0, 0, 0);
    fetch("beq_wk_t",     32'h100, BEQ, 0, 32'hF0,  1, 1, 0);
    for (int i = 0; i < 5; i++)
      res("sat_dec", 32'h10, BEQ, 0, 1, 32'h10, 0, 32'h0, 0, 32'h14, 32'h14, 1, 0, 0, 0);
    fetch("sat_lo",       32'h10, BEQ, 0, 32'h14, 1, 0, 0);
    res("inc_00", 32'h10, BEQ, 0, 1, 32'h10, 1, 32'h0, 1, 32'h0, 32'h14, 1, 0, 0, 0);
    res("inc_nobyp", 32'h10, BEQ, 0, 1, 32'h10, 1, 32'h0, 1, 32'h0, 32'h14, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      res("inc_hi", 32'h10, BEQ, 0, 1, 32'h10, 1, 32'h0, 1, 32'h0, 32'h0, 1, 1, 0, 0);
    fetch("sat_hi",       32'h10, BEQ, 0, 32'h0, 1, 1, 0);
    res("dec_hi1", 32'h10, BEQ, 0, 1, 32'h10, 0, 32'h0, 0, 32'h14, 32'h0, 1, 1, 0, 0);
    res("dec_hi2", 32'h10, BEQ, 0, 1, 32'h10, 0, 32'h0, 0, 32'h14, 32'h0, 1, 1, 0, 0);
    fetch("after_dec",    32'h10, BEQ, 0, 32'h14, 1, 0, 0);
    fetch("wrap",         32'hFFFF_FFFC, NOP, 0, 32'h0, 1, 0, 0);
    res("mp_wrap", 32'h40, NOP, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0, 32'h0, 1, 0, 1, 1);
    fetch("wrap_rec",     32'h0, NOP, 0, 32'h4, 1, 0, 1);
    res("mp_target", 32'h44, NOP, 0, 0, 32'h600, 1, 32'h700, 1, 32'h640, 32'h700, 1, 0, 1, 1);
    fetch("tgt_rec",      32'h700, NOP, 0, 32'h704, 1, 0, 1);
    vec("reset_mid", 1'b0, 32'h100, BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    vec("boot2",     1'b1, 32'h0,   NOP, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
    fetch("bht_reinit",   32'h100, BEQ, 0, 32'h104, 1, 0, 0);
    fetch("final_nop",    32'h104, NOP, 0, 32'h108, 1, 0, 0);

    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
